// File: rtl/thermo_stop_gen_pkg.sv
// Shared constants for the thermometer stop-column pattern generator:
// FSM encoding, bin limit derivation and the minimum bubble distance.
package thermo_stop_gen_pkg;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_SHOT       = 3'd1;
   localparam logic [2:0] ST_SWEEP_EMIT = 3'd2;
   localparam logic [2:0] ST_SWEEP_WAIT = 3'd3;
   localparam logic [2:0] ST_DONE       = 3'd4;

   // A bubble closer than this to the edge could fake a 0-1111 match.
   localparam logic [2:0] BUBBLE_MIN_OFS = 3'd2;

   // Highest bin the decoder can report; it needs room for the 0-1111 window.
   function automatic int bin_limit(input int num_ff);
      return num_ff - 20;
   endfunction

endpackage

// File: rtl/thermo_encode.sv
// Combinational bin -> thermometer word encoder with optional single bubble.
// Bin 0 yields all ones; bin b clears bits [b-1:0].
module thermo_encode
   import thermo_stop_gen_pkg::*;
#(
   parameter int NUM_FF    = 64,
   parameter int BITS_DECO = 8
) (
   input  logic [BITS_DECO-1:0] bin,
   input  logic                 bubble_en,
   input  logic [2:0]           bubble_ofs,
   output logic [NUM_FF-1:0]    word
);

   logic [2:0]  ofs_eff;
   logic [31:0] bin_w;
   logic [31:0] ofs_w;

   // Build the edge, then force one bit high below it when a bubble fits.
   always_comb begin
      ofs_eff = (bubble_ofs < BUBBLE_MIN_OFS) ? BUBBLE_MIN_OFS : bubble_ofs;
      bin_w   = 32'(bin);
      ofs_w   = 32'(ofs_eff);
      word    = '1;
      for (int i = 0; i < NUM_FF; i++) begin
         word[i] = (32'(i) >= bin_w);
         if (bubble_en && (bin_w >= ofs_w + 32'd1) && (32'(i) == bin_w - 32'd1 - ofs_w))
            word[i] = 1'b1;
      end
   end

endmodule

// File: rtl/thermo_stop_gen.sv
// Thermometer pattern generator: single-shot or swept bins at a programmable
// period, with the expected decoded bin presented alongside every word.
// Outputs are registered from the next-state logic, so a word shows up on the
// cycle right after the decision to emit it.
module thermo_stop_gen
   import thermo_stop_gen_pkg::*;
#(
   parameter int NUM_FF    = 64,
   parameter int BITS_DECO = 8,
   parameter int PERIOD_W  = 8
) (
   input  logic                 wClk,
   input  logic                 wRstN,
   input  logic                 wStartIn,
   input  logic                 wModeIn,
   input  logic                 wAbortIn,
   input  logic [BITS_DECO-1:0] wBinIn,
   input  logic [BITS_DECO-1:0] wBinMaxIn,
   input  logic [PERIOD_W-1:0]  wPeriodIn,
   input  logic                 wBubbleEnIn,
   input  logic [2:0]           wBubbleOfsIn,
   output logic [NUM_FF-1:0]    wPatOut,
   output logic                 wPatValidOut,
   output logic [BITS_DECO-1:0] wExpBinOut,
   output logic                 wBusyOut,
   output logic                 wDoneOut,
   output logic                 wErrOut
);

   localparam logic [BITS_DECO-1:0] LIM = BITS_DECO'(bin_limit(NUM_FF));

   logic [2:0]           st, st_n;
   logic [BITS_DECO-1:0] cur, cur_n;
   logic [BITS_DECO-1:0] max_bin, max_n;
   logic [PERIOD_W-1:0]  per, per_n;
   logic [PERIOD_W-1:0]  cnt, cnt_n;
   logic                 ben, ben_n;
   logic [2:0]           bofs, bofs_n;
   logic                 err_n, done_n, load_pat;
   logic [NUM_FF-1:0]    enc_word;

   thermo_encode #(.NUM_FF(NUM_FF), .BITS_DECO(BITS_DECO)) u_enc (
      .bin        (cur_n),
      .bubble_en  (ben_n),
      .bubble_ofs (bofs_n),
      .word       (enc_word)
   );

   // Next-state / next-output decision; load_pat means "present cur_n next cycle".
   always_comb begin
      st_n     = st;
      cur_n    = cur;
      max_n    = max_bin;
      per_n    = per;
      cnt_n    = cnt;
      ben_n    = ben;
      bofs_n   = bofs;
      err_n    = wErrOut;
      done_n   = 1'b0;
      load_pat = 1'b0;
      case (st)
         ST_IDLE: begin
            if (wStartIn) begin
               cur_n    = (wBinIn > LIM) ? LIM : wBinIn;
               max_n    = (wBinMaxIn > LIM) ? LIM : wBinMaxIn;
               per_n    = wPeriodIn;
               ben_n    = wBubbleEnIn;
               bofs_n   = wBubbleOfsIn;
               err_n    = (wBinIn > LIM) || (wModeIn && (wBinMaxIn > LIM));
               load_pat = 1'b1;
               st_n     = wModeIn ? ST_SWEEP_EMIT : ST_SHOT;
            end
         end
         ST_SHOT: begin
            st_n   = ST_DONE;
            done_n = 1'b1;
         end
         ST_SWEEP_EMIT: begin
            // >= also ends a sweep whose start bin exceeds its max (no wrap)
            if (wAbortIn || (cur >= max_bin)) begin
               st_n   = ST_DONE;
               done_n = 1'b1;
            end else if (per == '0) begin
               cur_n    = cur + 1'b1;
               load_pat = 1'b1;
            end else begin
               // one wait cycle is absorbed by the output register stage
               cnt_n = per - 1'b1;
               st_n  = ST_SWEEP_WAIT;
            end
         end
         ST_SWEEP_WAIT: begin
            if (wAbortIn) begin
               st_n   = ST_DONE;
               done_n = 1'b1;
            end else if (cnt == '0) begin
               cur_n    = cur + 1'b1;
               load_pat = 1'b1;
               st_n     = ST_SWEEP_EMIT;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ST_DONE: st_n = ST_IDLE;
         default: st_n = ST_IDLE;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge wClk or negedge wRstN) begin
      if (!wRstN) begin
         st           <= ST_IDLE;
         cur          <= '0;
         max_bin      <= '0;
         per          <= '0;
         cnt          <= '0;
         ben          <= 1'b0;
         bofs         <= '0;
         wPatOut      <= '1;
         wPatValidOut <= 1'b0;
         wExpBinOut   <= '0;
         wBusyOut     <= 1'b0;
         wDoneOut     <= 1'b0;
         wErrOut      <= 1'b0;
      end else begin
         st           <= st_n;
         cur          <= cur_n;
         max_bin      <= max_n;
         per          <= per_n;
         cnt          <= cnt_n;
         ben          <= ben_n;
         bofs         <= bofs_n;
         wPatValidOut <= load_pat;
         wBusyOut     <= (st_n != ST_IDLE);
         wDoneOut     <= done_n;
         wErrOut      <= err_n;
         if (load_pat) begin
            wPatOut    <= enc_word;
            wExpBinOut <= cur_n;
         end
      end
   end

endmodule

// File: doc/thermo_stop_gen.md
Name: thermo_stop_gen

Overview:
- Pattern generator and encoder: the inverse of the stop-column decoder.
- Converts a bin number into the NUM_FF-bit thermometer word a delay-line FF column would capture. Optionally injects one bubble.
- Can sweep bins automatically at a programmable period.
- Drives the decoder input in on-chip self-test and in simulation. Presents the expected decoded bin alongside each word for scoreboarding.

Parameters:
- NUM_FF, 64, width of the emulated FF column; must be >= 25.
- BITS_DECO, 8, width of bin fields; 2^BITS_DECO > NUM_FF-20.
- PERIOD_W, 8, width of the sweep period counter.

Ports:
- wClk  in  1  clock.
- wRstN  in  1  asynchronous active-low reset.
- wStartIn  in  1  one-cycle start pulse; ignored unless FSM is IDLE.
- wModeIn  in  1  0 = single shot, 1 = sweep; sampled with wStartIn.
- wAbortIn  in  1  abort sweep, return to IDLE.
- wBinIn  in  BITS_DECO  single-shot bin / sweep start bin.
- wBinMaxIn  in  BITS_DECO  sweep end bin, inclusive.
- wPeriodIn  in  PERIOD_W  cycles between sweep words minus 1.
- wBubbleEnIn  in  1  inject bubble.
- wBubbleOfsIn  in  3  bubble distance below edge, legal 2..7.
- wPatOut  out  NUM_FF  thermometer word.
- wPatValidOut  out  1  wPatOut/wExpBinOut valid this cycle.
- wExpBinOut  out  BITS_DECO  bin the decoder must report.
- wBusyOut  out  1  FSM not IDLE.
- wDoneOut  out  1  one-cycle pulse after last sweep word or abort.
- wErrOut  out  1  sticky: a requested bin was clamped; cleared by next accepted start.

Behaviour:
- Reset values: wPatOut all ones, all other outputs 0, FSM IDLE.
- Encoding of bin b (1 <= b <= NUM_FF-20): bits [b-1:0] = 0, bits [NUM_FF-1:b] = 1. The decoder reports b for this word.
- Bin 0 encodes as all ones; expected result 0.
- Bin greater than NUM_FF-20 is clamped to NUM_FF-20 and sets wErrOut.
- Bubble, when wBubbleEnIn=1:
  - Bit j = b-1-ofs is forced to 1, where ofs = max(wBubbleOfsIn, 2).
  - Applied only if j >= 0; otherwise no bubble.
  - wExpBinOut stays b, since a bubble at distance >= 2 never matches the decoder's 0-1111 search.
- All outputs are registered.
- FSM states: IDLE, SHOT, SWEEP_EMIT, SWEEP_WAIT, DONE.
- IDLE:
  - wPatOut holds its last word; wPatValidOut=0.
  - wStartIn with mode 0 goes to SHOT; with mode 1 goes to SWEEP_EMIT.
  - The first word appears exactly one cycle after the start cycle.
  - wBinIn, wBinMaxIn, wPeriodIn and the bubble controls are captured on start. Later input changes do not affect a running sweep.
- SHOT: word for captured bin, wPatValidOut=1 for one cycle, then DONE.
- SWEEP_EMIT: word for current bin, valid 1 cycle. Then:
  - if current bin == captured max, go to DONE;
  - else if period == 0, increment the bin and stay in SWEEP_EMIT (back-to-back valids);
  - else load the counter with the period and go to SWEEP_WAIT.
- SWEEP_WAIT: counts down to 0, then increments the bin and goes to SWEEP_EMIT. Gap between valids is period+1 cycles.
- Start bin greater than max: a single word for the start bin, then DONE (no wrap).
- Max beyond the clamp limit: the sweep ends at NUM_FF-20; wErrOut=1.
- DONE: wDoneOut=1 for one cycle, then IDLE.
- wAbortIn in any non-IDLE state goes to DONE next cycle; no further valid words.
- Abort has priority over emit when both happen in the same cycle.
- wStartIn while busy is ignored.
- wBusyOut=1 in all states except IDLE.
- Reset mid-sweep: immediate return to reset values; no wDoneOut.

Decomposition:
- Shared package/header holds:
  - FSM state encoding (3-bit localparams);
  - the BIN_LIMIT = NUM_FF-20 derivation;
  - the bubble minimum offset constant (2).
- The decoder uses the same NUM_FF-20 limit.
- Sub-module thermo_encode (combinational): bin, bubble enable and offset in; word out.
- The top module holds the FSM, bin counter, period counter and output registers.

Test Plan:
- Single shot, NUM_FF=64, bin 5, no bubble: wPatOut = 0xFFFF_FFFF_FFFF_FFE0, valid 1 cycle, 1 cycle after start, wExpBinOut=5, then wDoneOut.
- Bin 0 single shot: wPatOut all ones, wExpBinOut=0.
- Bin 60: wExpBinOut=44, wErrOut=1 sticky. The next start with bin 10 clears it.
- Sweep bins 1..44, period 0: 44 consecutive valid cycles. Each word fed to the decoder gives the matching wExpBinOut. wDoneOut on the cycle after the last word.
- Sweep 3..6, period 2: valids at t+1, t+4, t+7, t+10. Abort between 2nd and 3rd valid: no more valids, wDoneOut next cycle, busy drops.
- Bin 20 with bubble ofs 3: bit 16 set, bits 0-15 and 17-19 zero; decoder result 20. Ofs 0 is forced to 2: bit 17 set, decoder result 20.
